fir_sequencer: RTL
==================

// Module: fir_sequencer
// PURPOSE
// - Sequences one time-multiplexed multiply-accumulate unit over an NTAPS-tap FIR filter.
// - Input: 10-bit unsigned voltage samples, one valid strobe per sample, from the SPI capture path.
// - Output: 10-bit filtered samples with a one-cycle valid strobe.
// - Owns the sample history (circular buffer), the tap counter and the coefficient snapshot.
// PARAMETERS
// - NTAPS  3   number of filter taps (>=2)
// - CW     10  signed coefficient width
// - SHIFT  0   arithmetic right shift applied to the accumulator before saturation
// PORTS
// - clk             in   1         system clock, single clock domain
// - reset           in   1         asynchronous, active-low reset
// - sample_valid    in   1         one-cycle strobe: sample holds a new value
// - sample          in   10        unsigned ADC voltage, 0..1023
// - coef            in   NTAPS*CW  signed coefficients; h[k] = coef[CW*k +: CW]
// - filtered        out  10        saturated filter output
// - filtered_valid  out  1         one-cycle strobe: filtered is new
// - busy            out  1         high while a sample is being processed
// - overrun         out  1         sticky: a sample was dropped
// BEHAVIOUR
// - Reset (reset=0, any time, including mid-MAC):
//   - filtered=0, filtered_valid=0, busy=0, overrun=0.
//   - History buffer and write pointer cleared to 0; FSM goes to IDLE.
//   - The reset aborts any in-flight result; it is never output.
// - FSM states: IDLE -> LOAD -> MAC -> ROUND -> DONE -> IDLE.
//   - IDLE: sample_valid=1 captures sample and moves to LOAD.
//   - LOAD: writes the sample to buf[wptr]; snapshots coef; acc=0, tap=0.
//     Later coef changes do not affect the current result.
//   - MAC: exactly NTAPS cycles, acc += h[tap] * x[n-tap].
//     x[n-k] = buf[(wptr-k) mod NTAPS]; tap counts 0..NTAPS-1.
//   - ROUND: res = acc >>> SHIFT, saturated to [0,1023]; negative clamps to 0.
//   - DONE: filtered<=res and filtered_valid=1 for one cycle.
//     wptr advances and wraps from NTAPS-1 to 0; returns to IDLE.
// - Latency:
//   - filtered_valid rises exactly NTAPS+3 edges after the edge that accepts sample_valid.
//   - filtered holds its value until the next DONE.
// - Throughput: one sample per NTAPS+4 cycles.
// - busy: high from LOAD through DONE inclusive; low in IDLE.
// - Arithmetic:
//   - sample is zero-extended to 11-bit signed; the product is 11+CW bits.
//   - acc width is 11+CW+$clog2(NTAPS); no overflow is possible inside acc.
// - Boundaries:
//   - sample_valid while busy: handled per CONFIGURATION; overrun clears only on reset.
//   - sample_valid in the same cycle as DONE counts as while-busy.
//   - Before NTAPS samples have arrived, unwritten history reads as 0.
// CONFIGURATION
// - FIR_SKID_EN defined:
//   - A one-entry skid register captures the first sample that arrives while busy.
//   - It is processed immediately after DONE, going IDLE->LOAD on the next edge.
//   - overrun sets only if sample_valid arrives while the skid entry is already full.
//     That third sample is dropped; the skid keeps its older value.
// - FIR_SKID_EN undefined:
//   - Any sample_valid while busy is dropped and overrun sets on that edge.
// TESTING
// - Reset: hold reset=0 for 3 cycles -> filtered=0, filtered_valid=0, busy=0, overrun=0.
// - Impulse (NTAPS=3, SHIFT=0, h=1,2,3): samples 1,0,0,0 spaced 8 cycles apart
//   -> filtered 1,2,3,0; each valid exactly 6 edges after acceptance.
// - Wrap/steady-state (h=1,1,1): five samples of 100 -> filtered 100,200,300,300,300.
// - Saturation: h0=511, others 0, sample 1023 -> filtered=1023.
//   h0=-1, others 0, sample 5 -> filtered=0.
// - Overrun: second sample_valid 2 cycles after the first
//   -> macro off: one filtered_valid, overrun=1.
//   -> FIR_SKID_EN on: two filtered_valid pulses, overrun=0.
//      A third strobe while the skid is full -> overrun=1.
// - Reset mid-MAC: pulse reset=0 in MAC cycle 2 -> no filtered_valid.
//   Next impulse 1 with h=1,2,3 -> outputs 1,2,3 (history cleared).

Source files
------------

// File: rtl/fir_sequencer_if.sv
// Sample/result bus for fir_sequencer: master drives samples and coefficients,
// slave returns filtered results, status flags and its FSM state for debug.
interface fir_sequencer_if #(
   parameter int NTAPS = 3,
   parameter int CW    = 10
);
   // Handshake: sample_valid is a one-cycle strobe with no ready; a strobe that
   // arrives while busy is held in the skid entry (when present) or dropped and
   // flagged on overrun. filtered_valid is a one-cycle strobe, filtered holds.
   logic                  sample_valid;
   logic [9:0]            sample;
   logic [NTAPS*CW-1:0]   coef;
   logic [9:0]            filtered;
   logic                  filtered_valid;
   logic                  busy;
   logic                  overrun;
   logic [2:0]            fsm_state;

   modport master (
      output sample_valid, sample, coef,
      input  filtered, filtered_valid, busy, overrun, fsm_state
   );

   modport slave (
      input  sample_valid, sample, coef,
      output filtered, filtered_valid, busy, overrun, fsm_state
   );
endinterface

// File: rtl/fir_sequencer.sv
// Time-multiplexed single-MAC FIR over an NTAPS-deep circular sample history.
// Optional macro FIR_SKID_EN adds a one-entry skid register for samples arriving while busy.
module fir_sequencer #(
   parameter int NTAPS = 3,
   parameter int CW    = 10,
   parameter int SHIFT = 0
) (
   input logic            clk,
   input logic            reset,
   fir_sequencer_if.slave bus
);
   localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int PW = 11 + CW;
   localparam int AW = PW + $clog2(NTAPS);

   typedef enum logic [2:0] {IDLE, LOAD, MAC, ROUND, DONE} state_t;

   state_t                state, state_nx;
   logic [9:0]            cap;
   logic [9:0]            hist [NTAPS];
   logic [TW-1:0]         wptr, tap, rd_idx;
   logic [NTAPS*CW-1:0]   coef_snap;
   logic signed [AW-1:0]  acc, shifted;
   logic signed [10:0]    xs;
   logic signed [CW-1:0]  hs;
   logic signed [PW-1:0]  prod;
   logic [9:0]            res, res_sat;
   logic [9:0]            filtered_q;
   logic                  filtered_valid_q, overrun_q;
   logic                  accept, drop;
   logic [9:0]            accept_data;

`ifdef FIR_SKID_EN
   logic       skid_full;
   logic [9:0] skid;

   // The skid entry has priority in IDLE; a strobe in that same cycle refills it.
   assign accept      = (state == IDLE) && (bus.sample_valid || skid_full);
   assign accept_data = skid_full ? skid : bus.sample;
   assign drop        = (state != IDLE) && bus.sample_valid && skid_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_full <= 1'b0;
         skid      <= '0;
      end else if (state == IDLE) begin
         if (skid_full) begin
            skid_full <= bus.sample_valid;
            if (bus.sample_valid) skid <= bus.sample;
         end
      end else if (bus.sample_valid && !skid_full) begin
         skid_full <= 1'b1;
         skid      <= bus.sample;
      end
   end
`else
   assign accept      = (state == IDLE) && bus.sample_valid;
   assign accept_data = bus.sample;
   assign drop        = (state != IDLE) && bus.sample_valid;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = LOAD;
         LOAD:    state_nx = MAC;
         MAC:     if (tap == TW'(NTAPS - 1)) state_nx = ROUND;
         ROUND:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // x[n-tap] lives at (wptr - tap) mod NTAPS.
   always_comb begin
      rd_idx = wptr - tap;
      if (wptr < tap) rd_idx = wptr + TW'(NTAPS) - tap;
   end

   assign xs      = {1'b0, hist[rd_idx]};
   assign hs      = coef_snap[CW*tap +: CW];
   assign prod    = PW'(xs) * PW'(hs);
   assign shifted = acc >>> SHIFT;

   always_comb begin
      res_sat = shifted[9:0];
      if (shifted[AW-1])         res_sat = '0;
      else if (|shifted[AW-2:10]) res_sat = 10'h3FF;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap              <= '0;
         for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
         wptr             <= '0;
         tap              <= '0;
         coef_snap        <= '0;
         acc              <= '0;
         res              <= '0;
         filtered_q       <= '0;
         filtered_valid_q <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         filtered_valid_q <= 1'b0;
         if (drop) overrun_q <= 1'b1;
         case (state)
            IDLE: if (accept) cap <= accept_data;
            LOAD: begin
               hist[wptr] <= cap;
               coef_snap  <= bus.coef;
               acc        <= '0;
               tap        <= '0;
            end
            MAC: begin
               acc <= acc + $signed({{(AW-PW){prod[PW-1]}}, prod});
               tap <= tap + TW'(1);
            end
            ROUND: res <= res_sat;
            DONE: begin
               filtered_q       <= res;
               filtered_valid_q <= 1'b1;
               wptr             <= (wptr == TW'(NTAPS - 1)) ? '0 : wptr + TW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.filtered       = filtered_q;
   assign bus.filtered_valid = filtered_valid_q;
   assign bus.busy           = (state != IDLE);
   assign bus.overrun        = overrun_q;
   assign bus.fsm_state      = state;
endmodule
